cpu_trace_buffer: RTL and testbench

- Synthesizable, parametrised trace capture block for the single-cycle CPU.
- Samples each committed instruction (PC, instruction word, writeback data) into a circular buffer.
- Freezes capture a programmable number of commits after a trigger, then supplies the trace oldest-first through a request/valid readout port.
- Sits beside SingleCycleCPU and observes its PC, instruction, write-data and PCWre/RegWre signals.

---
 rtl/cpu_trace_buffer_if.sv | 51 +++++
 rtl/cpu_trace_buffer.sv | 173 +++++++++++++++++
 tb/tb_cpu_trace_buffer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_buffer_if.sv
// Bundle of the commit-observation bus, trigger configuration and readout port
// of the CPU trace buffer. The master side is the CPU/debug host, the slave side
// is the trace buffer itself.
interface cpu_trace_buffer_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16
) ();
   localparam int PTR_W = $clog2(DEPTH);

   // Commit observation
   logic              commit_in;
   logic [ADDR_W-1:0] pc_in;
   logic [DATA_W-1:0] instr_in;
   logic [DATA_W-1:0] wdata_in;
   logic              regwre_in;

   // Capture control
   logic              arm;
   logic [1:0]        trig_mode;
   logic [DATA_W-1:0] trig_value;
   logic [PTR_W-1:0]  post_count;

   // Readout
   logic              rd_req;
   logic              rd_valid;
   logic [ADDR_W-1:0] rd_pc;
   logic [DATA_W-1:0] rd_instr;
   logic [DATA_W-1:0] rd_wdata;
   logic              rd_regwre;
   logic              rd_last;

   // Status
   logic [1:0]        state;
   logic              wrapped;
   logic [PTR_W:0]    entries;

   modport master (
      output commit_in, pc_in, instr_in, wdata_in, regwre_in,
      output arm, trig_mode, trig_value, post_count, rd_req,
      input  rd_valid, rd_pc, rd_instr, rd_wdata, rd_regwre, rd_last,
      input  state, wrapped, entries
   );

   modport slave (
      input  commit_in, pc_in, instr_in, wdata_in, regwre_in,
      input  arm, trig_mode, trig_value, post_count, rd_req,
      output rd_valid, rd_pc, rd_instr, rd_wdata, rd_regwre, rd_last,
      output state, wrapped, entries
   );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Trace capture buffer for the single-cycle CPU. Records committed instructions
// into a circular RAM, stops a programmable number of commits after a trigger,
// then plays the trace back oldest-first through a request/valid port.
module cpu_trace_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input logic               clk,
   input logic               Reset,
   cpu_trace_buffer_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
      logic [DATA_W-1:0] wdata;
      logic              regwre;
   } entry_t;

   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   entry_t mem [DEPTH];

   state_e           state_q,    state_d;
   logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
   logic [PTR_W-1:0] post_cnt_q, post_cnt_d;
   logic             wrapped_q,  wrapped_d;
   logic [PTR_W:0]   entries_q,  entries_d;
   logic [PTR_W:0]   rd_cnt_q,   rd_cnt_d;
   logic             rd_valid_q, rd_valid_d;
   logic             rd_last_q,  rd_last_d;
   entry_t           rd_data_q,  rd_data_d;

   logic             capture;
   logic             trig_hit;
   logic             rd_fire;

   // Trigger condition for the commit currently on the bus.
   always_comb begin
      trig_hit = 1'b0;
      unique case (bus.trig_mode)
         2'd0:    trig_hit = 1'b1;
         2'd1:    trig_hit = (bus.pc_in == bus.trig_value[ADDR_W-1:0]);
         2'd2:    trig_hit = (bus.instr_in == bus.trig_value);
         default: trig_hit = 1'b0;
      endcase
   end

   // Next-state logic for capture control and the readout side.
   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      post_cnt_d = post_cnt_q;
      wrapped_d  = wrapped_q;
      entries_d  = entries_q;
      rd_cnt_d   = rd_cnt_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = rd_data_q;
      capture    = 1'b0;
      rd_fire    = 1'b0;

      if (bus.arm) begin
         // Arm restarts everything; a same-cycle commit or read is dropped.
         state_d    = S_ARMED;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         post_cnt_d = '0;
         wrapped_d  = 1'b0;
         entries_d  = '0;
         rd_cnt_d   = '0;
         rd_data_d  = '0;
      end else begin
         capture = bus.commit_in && (state_q == S_ARMED || state_q == S_POST);
         if (capture) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (wr_ptr_q == PTR_LAST) wrapped_d = 1'b1;
            if (entries_q != CNT_FULL) entries_d = entries_q + CNT_ONE;

            if (state_q == S_ARMED && trig_hit) begin
               // post_count is PTR_W wide, so it can never exceed DEPTH-1 and
               // the trigger entry always survives the post-trigger window.
               if (bus.post_count == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d    = S_POST;
                  post_cnt_d = bus.post_count;
               end
            end else if (state_q == S_POST) begin
               post_cnt_d = post_cnt_q - PTR_ONE;
               if (post_cnt_q == PTR_ONE) state_d = S_DONE;
            end

            // Point the read side at the oldest entry as capture freezes.
            if (state_d == S_DONE) rd_ptr_d = wrapped_d ? wr_ptr_d : '0;
         end

         rd_fire = (state_q == S_DONE) && bus.rd_req && (rd_cnt_q != entries_q);
         if (rd_fire) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            rd_cnt_d   = rd_cnt_q + CNT_ONE;
            rd_valid_d = 1'b1;
            rd_last_d  = ((rd_cnt_q + CNT_ONE) == entries_q);
         end
      end
   end

   // Control and readout registers with asynchronous reset.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_cnt_q <= '0;
         wrapped_q  <= 1'b0;
         entries_q  <= '0;
         rd_cnt_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_last_q  <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         // NOTE: registers are updated with non-blocking assignments so all flops sample the same pre-edge values.
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         post_cnt_q <= post_cnt_d;
         wrapped_q  <= wrapped_d;
         entries_q  <= entries_d;
         rd_cnt_q   <= rd_cnt_d;
         rd_valid_q <= rd_valid_d;
         rd_last_q  <= rd_last_d;
         rd_data_q  <= rd_data_d;
      end
   end

   // Trace RAM write port.
   always_ff @(posedge clk) begin
      // NOTE: the RAM has no reset; entries are only read after being written under entries_q.
      if (capture) begin
         mem[wr_ptr_q] <= '{pc:     bus.pc_in,
                            instr:  bus.instr_in,
                            wdata:  bus.wdata_in,
                            regwre: bus.regwre_in};
      end
   end

   assign bus.rd_valid  = rd_valid_q;
   assign bus.rd_last   = rd_last_q;
   assign bus.rd_pc     = rd_data_q.pc;
   assign bus.rd_instr  = rd_data_q.instr;
   assign bus.rd_wdata  = rd_data_q.wdata;
   assign bus.rd_regwre = rd_data_q.regwre;
   assign bus.state     = state_q;
   assign bus.wrapped   = wrapped_q;
   assign bus.entries   = entries_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Self-checking bench for cpu_trace_buffer: a table of commit vectors with
// expected status, hand-written corner sequences, and a readout scoreboard.
module tb_cpu_trace_buffer;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 16;
   localparam int PTR_W  = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] wdata;
      logic        regwre;
      logic        last;
   } exp_t;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  st;
      logic [4:0]  ent;
   } vec_t;

   logic clk   = 1'b0;
   logic Reset = 1'b1;

   exp_t sb_q[$];
   exp_t stored_q[$];
   exp_t mon_e;
   vec_t vecs[6];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cpu_trace_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   cpu_trace_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .Reset (Reset),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'h1300_0000 ^ pc;
   endfunction

   function automatic logic [31:0] wdata_of(input logic [31:0] pc);
      return 32'hDEAD_0000 + pc;
   endfunction

   task automatic do_arm(input logic [1:0] mode, input logic [31:0] tv,
                         input logic [PTR_W-1:0] pcnt, input logic with_commit,
                         input logic with_rd);
      bus.arm        = 1'b1;
      bus.trig_mode  = mode;
      bus.trig_value = tv;
      bus.post_count = pcnt;
      bus.commit_in  = with_commit;
      bus.pc_in      = 32'hFFF0;
      bus.instr_in   = instr_of(32'hFFF0);
      bus.rd_req     = with_rd;
      tick();
      bus.arm       = 1'b0;
      bus.commit_in = 1'b0;
      bus.rd_req    = 1'b0;
      stored_q.delete();
   endtask

   task automatic do_commit(input logic [31:0] pc, input logic [31:0] instr, input bit store);
      exp_t e;
      bus.commit_in = 1'b1;
      bus.pc_in     = pc;
      bus.instr_in  = instr;
      bus.wdata_in  = wdata_of(pc);
      bus.regwre_in = pc[2];
      tick();
      bus.commit_in = 1'b0;
      if (store) begin
         e.pc     = pc;
         e.instr  = instr;
         e.wdata  = wdata_of(pc);
         e.regwre = pc[2];
         e.last   = 1'b0;
         stored_q.push_back(e);
         if (stored_q.size() > DEPTH) void'(stored_q.pop_front());
      end
   endtask

   task automatic read_all(input int n, input bit gap);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         bus.rd_req = 1'b1;
         e      = stored_q[i];
         e.last = (i == n - 1);
         sb_q.push_back(e);
         tick();
         bus.rd_req = 1'b0;
         if (gap) tick();
      end
   endtask

   task automatic drain(input string name);
      tick();
      tick();
      for (int i = 0; i < 4 && sb_q.size() != 0; i++) tick();
      check(name, sb_q.size(), 0);
   endtask

   // Scoreboard: every rd_valid must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rd_valid: got rd_valid=1 rd_pc=%0h, expected no rd_valid", bus.rd_pc);
         end else begin
            mon_e = sb_q.pop_front();
            check("rd_pc",     bus.rd_pc,     mon_e.pc);
            check("rd_instr",  bus.rd_instr,  mon_e.instr);
            check("rd_wdata",  bus.rd_wdata,  mon_e.wdata);
            check("rd_regwre", bus.rd_regwre, mon_e.regwre);
            check("rd_last",   bus.rd_last,   mon_e.last);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1);
   end

   initial begin
      // Immediate trigger, post_count=3: trigger + 3 stored, then frozen.
      for (int i = 0; i < 6; i++) begin
         vecs[i].pc  = 32'(4 * i);
         vecs[i].st  = (i < 3) ? 2'd2 : 2'd3;
         vecs[i].ent = (i < 4) ? 5'(i + 1) : 5'd4;
      end

      bus.commit_in  = 1'b0;
      bus.pc_in      = '0;
      bus.instr_in   = '0;
      bus.wdata_in   = '0;
      bus.regwre_in  = 1'b0;
      bus.arm        = 1'b0;
      bus.trig_mode  = 2'd0;
      bus.trig_value = '0;
      bus.post_count = '0;
      bus.rd_req     = 1'b0;

      // ---- 1: reset state, idle ignores requests and commits ----
      Reset = 1'b1;
      repeat (3) tick();
      check("rst_state",    bus.state,     0);
      check("rst_entries",  bus.entries,   0);
      check("rst_wrapped",  bus.wrapped,   0);
      check("rst_rd_valid", bus.rd_valid,  0);
      check("rst_rd_last",  bus.rd_last,   0);
      check("rst_rd_pc",    bus.rd_pc,     0);
      check("rst_rd_instr", bus.rd_instr,  0);
      check("rst_rd_wdata", bus.rd_wdata,  0);
      check("rst_rd_regwe", bus.rd_regwre, 0);
      Reset = 1'b0;
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();
      check("idle_rd_valid", bus.rd_valid, 0);
      do_commit(32'h40, instr_of(32'h40), 1'b0);
      check("idle_entries", bus.entries, 0);
      check("idle_state",   bus.state,   0);

      // ---- 2: immediate trigger, table-driven commits, readout ----
      do_arm(2'd0, 32'h0, 4'd3, 1'b0, 1'b0);
      check("t2_armed",   bus.state,   1);
      check("t2_entries", bus.entries, 0);
      for (int i = 0; i < 6; i++) begin
         do_commit(vecs[i].pc, instr_of(vecs[i].pc), i < 4);
         check($sformatf("t2_state_%0d", i),   bus.state,   vecs[i].st);
         check($sformatf("t2_entries_%0d", i), bus.entries, vecs[i].ent);
      end
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         bus.rd_req = 1'b1;
         e      = stored_q[i];
         e.last = (i == 3);
         sb_q.push_back(e);
         tick();
         if (i == 0) check("t2_latency", bus.rd_valid, 1);
      end
      tick();                        // fifth request, nothing left to read
      bus.rd_req = 1'b0;
      tick();
      check("t2_no_fifth", bus.rd_valid, 0);
      check("t2_hold_pc",  bus.rd_pc,    32'hC);
      drain("t2_drain");

      // ---- 3: PC match with wrap ----
      do_arm(2'd1, 32'h50, 4'd2, 1'b0, 1'b0);
      for (int i = 0; i < 23; i++) begin
         do_commit(32'(4 * i), instr_of(32'(4 * i)), 1'b1);
         if (i == 19) check("t3_pre_trig", bus.state, 1);
         if (i == 20) check("t3_post",     bus.state, 2);
      end
      check("t3_state",   bus.state,   3);
      check("t3_wrapped", bus.wrapped, 1);
      check("t3_entries", bus.entries, 16);
      read_all(16, 1'b0);
      drain("t3_drain");

      // ---- 4: instruction match, commits with gaps, post_count=0 ----
      do_arm(2'd2, 32'h0801_0001, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         logic [31:0] pc;
         pc = 32'h100 + 32'(4 * i);
         do_commit(pc, (i == 4) ? 32'h0801_0001 : instr_of(pc), 1'b1);
         if (i < 4) check($sformatf("t4_entries_%0d", i), bus.entries, i + 1);
         tick();
      end
      check("t4_state",   bus.state,   3);
      check("t4_entries", bus.entries, 5);
      check("t4_wrapped", bus.wrapped, 0);
      do_commit(32'h200, instr_of(32'h200), 1'b0);
      check("t4_frozen",  bus.entries, 5);
      read_all(5, 1'b1);
      drain("t4_drain");

      // ---- 5: arm/commit collision, re-arm with read, clamp, free-run ----
      do_arm(2'd0, 32'h0, 4'd0, 1'b1, 1'b0);
      check("t5_coll_entries", bus.entries, 0);
      check("t5_coll_state",   bus.state,   1);
      do_commit(32'h200, instr_of(32'h200), 1'b1);
      check("t5_done",         bus.state,   3);
      check("t5_one",          bus.entries, 1);
      do_arm(2'd0, 32'h0, PTR_W'(DEPTH), 1'b0, 1'b1);
      check("t5_rearm_entries", bus.entries,  0);
      check("t5_rearm_state",   bus.state,    1);
      check("t5_rearm_no_read", bus.rd_valid, 0);
      do_commit(32'h300, instr_of(32'h300), 1'b1);
      check("t5_pc16_state",   bus.state,   3);
      check("t5_pc16_entries", bus.entries, 1);
      read_all(1, 1'b0);
      drain("t5_pc16_drain");

      do_arm(2'd0, 32'h0, 4'd15, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) do_commit(32'h400 + 32'(4 * i), instr_of(32'h400 + 32'(4 * i)), 1'b1);
      check("t5_clamp_state",   bus.state,   3);
      check("t5_clamp_entries", bus.entries, 16);
      check("t5_clamp_wrapped", bus.wrapped, 1);
      do_commit(32'h800, instr_of(32'h800), 1'b0);
      check("t5_clamp_frozen",  bus.entries, 16);
      read_all(16, 1'b0);
      drain("t5_clamp_drain");

      do_arm(2'd3, 32'h0, 4'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) do_commit(32'h900 + 32'(4 * i), instr_of(32'h900 + 32'(4 * i)), 1'b1);
      check("t5_free_state",   bus.state,   1);
      check("t5_free_entries", bus.entries, 16);
      check("t5_free_wrapped", bus.wrapped, 1);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();
      check("t5_free_no_read", bus.rd_valid, 0);

      // ---- 6: asynchronous reset in POST ----
      do_arm(2'd0, 32'h0, 4'd3, 1'b0, 1'b0);
      do_commit(32'hA00, instr_of(32'hA00), 1'b0);
      do_commit(32'hA04, instr_of(32'hA04), 1'b0);
      check("t6_post_state",   bus.state,   2);
      check("t6_post_entries", bus.entries, 2);
      #2;
      Reset = 1'b1;
      #1;
      check("t6_async_state",   bus.state,    0);
      check("t6_async_entries", bus.entries,  0);
      check("t6_async_valid",   bus.rd_valid, 0);
      check("t6_async_rd_pc",   bus.rd_pc,    0);
      #3;
      Reset = 1'b0;
      tick();
      do_commit(32'hA08, instr_of(32'hA08), 1'b0);
      do_commit(32'hA0C, instr_of(32'hA0C), 1'b0);
      check("t6_ignored_entries", bus.entries, 0);
      check("t6_ignored_state",   bus.state,   0);
      bus.rd_req = 1'b1;
      tick();
      bus.rd_req = 1'b0;
      tick();
      check("t6_no_read", bus.rd_valid, 0);
      do_arm(2'd0, 32'h0, 4'd0, 1'b0, 1'b0);
      do_commit(32'hB00, instr_of(32'hB00), 1'b1);
      check("t6_recover_state", bus.state, 3);
      read_all(1, 1'b0);
      drain("t6_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
